// File: rtl/hex_ascii_parser_if.sv
// Character-in / word-out handshake bundle for the hex ASCII parser.
// The environment drives characters and word_ready; the parser answers through the slave modport.
interface hex_ascii_parser_if #(
  parameter int NIBBLES = 4
);
  logic                   char_valid;
  logic [7:0]             char_data;
  logic                   char_ready;
  logic                   word_valid;
  logic [4*NIBBLES-1:0]   word_data;
  logic [3:0]             word_count;
  logic                   word_ready;
  logic                   error;

  modport master (
    output char_valid, char_data, word_ready,
    input  char_ready, word_valid, word_data, word_count, error
  );

  modport slave (
    input  char_valid, char_data, word_ready,
    output char_ready, word_valid, word_data, word_count, error
  );
endinterface

// File: rtl/hex_ascii_parser.sv
// Assembles a stream of ASCII hex digits into a binary word (last digit in [3:0]).
// Optional macro LOWERCASE_HEX_EN makes 'a'-'f' decode like 'A'-'F'.
module hex_ascii_parser #(
  parameter int NIBBLES = 4
) (
  input logic              clk,
  input logic              reset,
  hex_ascii_parser_if.slave bus
);
  localparam int W = 4 * NIBBLES;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   acc, acc_nxt, acc_shift;
  logic [3:0]     cnt, cnt_nxt, cnt_inc;
  logic           err_q, err_nxt;
  logic           is_digit, is_delim, xfer;
  logic [3:0]     nib;

  always_comb begin
    is_digit = 1'b0;
    nib      = 4'h0;
    if (bus.char_data >= 8'h30 && bus.char_data <= 8'h39) begin
      is_digit = 1'b1;
      nib      = bus.char_data[3:0];
    end else if (bus.char_data >= 8'h41 && bus.char_data <= 8'h46) begin
      is_digit = 1'b1;
      nib      = bus.char_data[3:0] + 4'd9;
`ifdef LOWERCASE_HEX_EN
    end else if (bus.char_data >= 8'h61 && bus.char_data <= 8'h66) begin
      is_digit = 1'b1;
      nib      = bus.char_data[3:0] + 4'd9;
`endif
    end
  end

  assign is_delim = (bus.char_data == 8'h20) || (bus.char_data == 8'h0D) ||
                    (bus.char_data == 8'h0A) || (bus.char_data == 8'h2C);

  // A single-nibble word has nothing to shift up, so the slice only exists for wider words.
  generate
    if (NIBBLES > 1) begin : g_shift
      assign acc_shift = {acc[W-5:0], nib};
    end else begin : g_noshift
      assign acc_shift = nib;
    end
  endgenerate

  assign cnt_inc        = cnt + 4'd1;
  assign bus.char_ready = !reset && (state != EMIT);
  assign xfer           = bus.char_valid && bus.char_ready;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (is_digit) begin
            acc_nxt   = W'(nib);
            cnt_nxt   = 4'd1;
            state_nxt = (NIBBLES == 1) ? EMIT : ACCUM;
          end else if (!is_delim) begin
            err_nxt = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (xfer) begin
          if (is_digit) begin
            acc_nxt = acc_shift;
            cnt_nxt = cnt_inc;
            if (cnt_inc == 4'(NIBBLES)) state_nxt = EMIT;
          end else if (is_delim) begin
            state_nxt = EMIT;
          end else begin
            // Bad character drops the partial word entirely.
            err_nxt   = 1'b1;
            acc_nxt   = '0;
            cnt_nxt   = 4'd0;
            state_nxt = IDLE;
          end
        end
      end
      EMIT: begin
        if (bus.word_ready) begin
          acc_nxt   = '0;
          cnt_nxt   = 4'd0;
          state_nxt = IDLE;
        end
      end
      default: begin
        acc_nxt   = '0;
        cnt_nxt   = 4'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= 4'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
    end
  end

  // All word outputs come straight from registers, so they hold steady through back-pressure.
  assign bus.word_valid = (state == EMIT);
  assign bus.word_data  = acc;
  assign bus.word_count = cnt;
  assign bus.error      = err_q;
endmodule

// File: tb/tb_hex_ascii_parser.sv
// Scoreboard bench for hex_ascii_parser: stimulus pushes expected words/error pulses, a monitor pops them.
module tb_hex_ascii_parser;
  logic clk;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  typedef struct {
    bit          is_err;
    logic [15:0] data;
    logic [3:0]  cnt;
  } ev_t;
  ev_t exp_q[$];

  hex_ascii_parser_if #(.NIBBLES(4)) bus ();

  hex_ascii_parser #(.NIBBLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic exp_word(input logic [15:0] d, input logic [3:0] c);
    ev_t e;
    e.is_err = 1'b0; e.data = d; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic exp_err();
    ev_t e;
    e.is_err = 1'b1; e.data = '0; e.cnt = '0;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_char(input logic [7:0] c);
    int n = 0;
    bus.char_valid = 1'b1;
    bus.char_data  = c;
    while (!bus.char_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      compared++;
      mismatched++;
      $display("FAIL char_accept_timeout: char 0x%0h never accepted, required acceptance", c);
    end
    @(posedge clk); #1;
    bus.char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.error) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL error_pulse: got unexpected error pulse, required nothing");
        end else begin
          if (!exp_q[0].is_err) begin
            mismatched++;
            $display("FAIL error_pulse: got error pulse, required word 0x%0h", exp_q[0].data);
          end
          void'(exp_q.pop_front());
        end
      end
      if (bus.word_valid && bus.word_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL word_out: got unexpected word 0x%0h/%0d, required nothing",
                   bus.word_data, bus.word_count);
        end else begin
          if (exp_q[0].is_err || bus.word_data !== exp_q[0].data || bus.word_count !== exp_q[0].cnt) begin
            mismatched++;
            $display("FAIL word_out: got 0x%0h/%0d (err_expected=%0d), required 0x%0h/%0d",
                     bus.word_data, bus.word_count, exp_q[0].is_err, exp_q[0].data, exp_q[0].cnt);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset          = 1'b1;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.word_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_char_ready", bus.char_ready, 0);
    check("rst_word_valid", bus.word_valid, 0);
    check("rst_word_data", bus.word_data, 0);
    check("rst_word_count", bus.word_count, 0);
    check("rst_error", bus.error, 0);
    reset = 1'b0;
    #1;
    check("post_rst_char_ready", bus.char_ready, 1);

    // 1: auto-terminate at 4 digits, trailing space ignored
    exp_word(16'h1A3F, 4);
    send_str("1A3F");
    check("t1_valid_after_4th", bus.word_valid, 1);
    send_char(8'h20);
    idle(3);

    // 2: single digit terminated by CR
    exp_word(16'h0007, 1);
    send_char("7");
    check("t2_no_valid_before_cr", bus.word_valid, 0);
    send_char(8'h0D);
    check("t2_valid_after_cr", bus.word_valid, 1);
    check("t2_count", bus.word_count, 1);
    idle(3);

    // 3: invalid char drops "12"
    exp_err();
    exp_word(16'h0004, 1);
    send_str("12G4 ");
    idle(3);

    // 4: overflow splits into two words
    exp_word(16'h1234, 4);
    exp_word(16'h0056, 2);
    send_str("123456,");
    idle(3);

    // 5: back-pressure in EMIT with a pending character
    bus.word_ready = 1'b0;
    exp_word(16'h0009, 1);
    send_str("9,");
    bus.char_valid = 1'b1;
    bus.char_data  = "3";
    for (int i = 0; i < 3; i++) begin
      check("t5_hold_valid", bus.word_valid, 1);
      check("t5_hold_data", bus.word_data, 16'h0009);
      check("t5_hold_count", bus.word_count, 1);
      check("t5_char_ready_low", bus.char_ready, 0);
      @(posedge clk); #1;
    end
    exp_word(16'h0003, 1);
    bus.word_ready = 1'b1;
    send_char("3");
    send_char(",");
    idle(3);

    // 6: lowercase handling depends on build option
`ifdef LOWERCASE_HEX_EN
    exp_word(16'h00AB, 2);
`else
    exp_err();
    exp_err();
`endif
    send_str("ab,");
    idle(3);

    // 7: reset mid-word discards the partial value
    send_str("12");
    reset = 1'b1;
    #1;
    check("t7_rst_word_valid", bus.word_valid, 0);
    check("t7_rst_word_data", bus.word_data, 0);
    check("t7_rst_word_count", bus.word_count, 0);
    check("t7_rst_char_ready", bus.char_ready, 0);
    check("t7_rst_error", bus.error, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    exp_word(16'h0005, 1);
    send_str("5 ");
    idle(5);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
endmodule
